// File: rtl/control_unit.sv
// Multi-cycle fetch/decode control unit for the 8-bit datapath.
// Drives register bank selects/strobes and ALU opcode; owns PC and zero flag.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       alu_zero,
    output logic [1:0] rf_sr1,
    output logic [1:0] rf_sr2,
    output logic [1:0] rf_dr,
    output logic       rf_write,
    output logic       rf_wr_sel,
    output logic [7:0] imm,
    output logic [2:0] alu_op,
    output logic       zflag,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_IMM,
        S_EXEC,
        S_HALT
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [3:0] opc;
    logic       is_alu;
    logic       in_exec;

    assign opc     = ir[7:4];
    assign is_alu  = (opc >= 4'h1) && (opc <= 4'h7);
    assign in_exec = (state == S_EXEC);

    function automatic logic two_byte(input logic [3:0] op);
        return (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= 8'h00;
            ir    <= 8'h00;
            imm   <= 8'h00;
            zflag <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir    <= imem_data;
                    pc    <= pc + 8'h01;
                    state <= two_byte(imem_data[7:4]) ? S_FETCH2 : S_EXEC;
                end
                S_FETCH2: state <= S_IMM;
                S_IMM: begin
                    imm   <= imem_data;
                    pc    <= pc + 8'h01;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    if (is_alu || opc == 4'hB)
                        zflag <= alu_zero;
                    if (opc == 4'h9 || (opc == 4'hA && zflag))
                        pc <= imm;
                    if (opc == 4'hF)
                        state <= S_HALT;
                end
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Strobes decode from state/IR; reset gates the write so an
    // interrupted EXEC never commits.
    always_comb begin
        alu_op = 3'd0;
        if (in_exec && is_alu)
            alu_op = opc[2:0] - 3'd1;
        else if (in_exec && opc == 4'hB)
            alu_op = 3'd1;
    end

    assign rf_write  = in_exec && (is_alu || opc == 4'h8) && !reset;
    assign rf_wr_sel = in_exec && (opc == 4'h8);
    assign halted    = (state == S_HALT);
    assign imem_addr = pc;
    assign rf_sr1    = ir[3:2];
    assign rf_sr2    = ir[1:0];
    assign rf_dr     = ir[3:2];

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: expected register writes are queued
// when a program is loaded and matched against each rf_write pulse.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       alu_zero = 1'b0;
    logic [1:0] rf_sr1, rf_sr2, rf_dr;
    logic       rf_write, rf_wr_sel;
    logic [7:0] imm;
    logic [2:0] alu_op;
    logic       zflag, halted;

    control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .alu_zero  (alu_zero),
        .rf_sr1    (rf_sr1),
        .rf_sr2    (rf_sr2),
        .rf_dr     (rf_dr),
        .rf_write  (rf_write),
        .rf_wr_sel (rf_wr_sel),
        .imm       (imm),
        .alu_op    (alu_op),
        .zflag     (zflag),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) imem_data <= mem[imem_addr];

    // cyc is 1 in the first FETCH cycle after reset release
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] dr;
        logic       sel;
        logic [7:0] imm;
        logic [2:0] op;
    } wr_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rf_write) begin
            if (sb.size() == 0) begin
                chk("spurious_wr", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_cyc", cyc, e.cyc);
                chk("wr_dr", rf_dr, e.dr);
                chk("wr_sel", rf_wr_sel, e.sel);
                if (e.sel) chk("wr_imm", imm, e.imm);
                chk("wr_op", alu_op, e.op);
            end
        end
    end

    task automatic push(input int c, input logic [1:0] d, input logic s,
                        input logic [7:0] i, input logic [2:0] o);
        wr_t e;
        e.cyc = c; e.dr = d; e.sel = s; e.imm = i; e.op = o;
        sb.push_back(e);
    endtask

    task automatic to_cyc(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) chk("timeout", cyc, n);
    endtask

    task automatic start_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        // LDI r0,#5 ; LDI r3,#3 ; ADD r1,r3
        mem[0] = 8'h81; mem[1] = 8'h05; mem[2] = 8'h8D;
        mem[3] = 8'h03; mem[4] = 8'h17;
        push(5, 2'd0, 1'b1, 8'h05, 3'd0);
        push(10, 2'd3, 1'b1, 8'h03, 3'd0);
        push(13, 2'd1, 1'b0, 8'h00, 3'd0);
        release_reset();
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_zflag", zflag, 0);
        chk("rst_halted", halted, 0);
        chk("rst_imm", imm, 8'h00);
        chk("rst_aluop", alu_op, 0);
        chk("rst_wr", rf_write, 0);
        chk("rst_wrsel", rf_wr_sel, 0);
        chk("rst_dr", rf_dr, 0);
        to_cyc(13);
        chk("add_sr2", rf_sr2, 3);
        to_cyc(16);
        chk("sb_drain1", sb.size(), 0);

        // CMP r0,r1 with zero, then JZ 0x40 taken / not taken
        for (int z = 1; z >= 0; z--) begin
            start_reset();
            mem[0] = 8'hB1; mem[1] = 8'hA0; mem[2] = 8'h40;
            alu_zero = z[0];
            release_reset();
            to_cyc(3);
            chk("cmp_op", alu_op, 1);
            to_cyc(4);
            chk("cmp_z", zflag, z);
            alu_zero = 1'b0;
            to_cyc(9);
            chk("jz_addr", imem_addr, z ? 8'h40 : 8'h03);
        end

        // JMP 0xFE ; at 0xFE: JMP 0x10 (immediate at 0xFF)
        start_reset();
        mem[0] = 8'h90; mem[1] = 8'hFE;
        mem[8'hFE] = 8'h90; mem[8'hFF] = 8'h10; mem[8'h10] = 8'hF0;
        release_reset();
        to_cyc(6);
        chk("jmp1_addr", imem_addr, 8'hFE);
        to_cyc(10);
        chk("jmp2_imm", imm, 8'h10);
        to_cyc(11);
        chk("jmp2_addr", imem_addr, 8'h10);

        // LDI at 0xFF takes its immediate from 0x00 after PC wraps
        start_reset();
        mem[0] = 8'h90; mem[1] = 8'hFF; mem[8'hFF] = 8'h84;
        push(10, 2'd1, 1'b1, 8'h90, 3'd0);
        release_reset();
        to_cyc(8);
        chk("wrap_addr", imem_addr, 8'h00);
        to_cyc(11);
        chk("wrap_next", imem_addr, 8'h01);
        chk("sb_drain2", sb.size(), 0);

        // HALT holds for 20 cycles, reset restarts
        start_reset();
        mem[0] = 8'hF0;
        release_reset();
        to_cyc(3);
        chk("pre_halt", halted, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_flag", halted, 1);
            chk("halt_addr", imem_addr, 8'h01);
        end
        start_reset();
        release_reset();
        chk("unhalt_flag", halted, 0);
        chk("unhalt_addr", imem_addr, 8'h00);

        // reset asserted during EXEC of ADD discards it
        start_reset();
        mem[0] = 8'h17;
        release_reset();
        to_cyc(2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_exec_wr", rf_write, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        push(3, 2'd1, 1'b0, 8'h00, 3'd0);
        @(negedge clk);
        chk("rst_exec_pc", imem_addr, 8'h00);
        to_cyc(4);
        chk("sb_drain3", sb.size(), 0);

        // CMP sets zflag, then illegal 0xC5 does nothing
        start_reset();
        mem[0] = 8'hB1; mem[1] = 8'hC5;
        alu_zero = 1'b1;
        release_reset();
        to_cyc(4);
        alu_zero = 1'b0;
        chk("c5_addr0", imem_addr, 8'h01);
        to_cyc(6);
        chk("c5_op", alu_op, 0);
        to_cyc(7);
        chk("c5_addr", imem_addr, 8'h02);
        chk("c5_z", zflag, 1);
        chk("sb_final", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit for the 8-bit datapath. It fetches one- or two-byte instructions from a synchronous-read instruction memory and decodes them. It then drives the register bank (source/destination selects, write strobe, write-data source) and the ALU opcode, and keeps the PC and zero flag. It sits directly upstream of the register bank and ALU and is the only source of their control signals.

## Interface
- No parameters; data width 8 bits, register select 2 bits (4 registers), PC 8 bits.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_addr  out  8  instruction memory address, equal to the PC
- imem_data  in  8  instruction memory read data, valid the cycle after imem_addr is presented
- alu_zero  in  1  ALU result == 0, combinational on the current operands/op
- rf_sr1  out  2  register bank source 1 select = IR[3:2]
- rf_sr2  out  2  register bank source 2 select = IR[1:0]
- rf_dr  out  2  register bank destination select = IR[3:2]
- rf_write  out  1  register bank write strobe, one cycle
- rf_wr_sel  out  1  write-data source: 0 = ALU result, 1 = imm
- imm  out  8  immediate byte register
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS B
- zflag  out  1  zero flag register
- halted  out  1  high in HALT state

## Operation
- Instruction byte: IR[7:4] opcode, IR[3:2] rd (also source A), IR[1:0] rs (source B).
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 NOT (rd = ~rd); 7 MOV (rd = rs, ALU PASS B); 8 LDI rd,#imm; 9 JMP #addr; A JZ #addr; B CMP (rd - rs, flags only); F HALT; C-E execute as NOP.
- Two-byte opcodes 8, 9 and A take their second byte from PC+1.
- States: FETCH -> DECODE -> (two-byte: FETCH2 -> IMM ->) EXEC -> FETCH; HALT is absorbing.
- FETCH/FETCH2: imem_addr = pc; no state update except the transition.
- DECODE: IR <= imem_data, pc <= pc+1.
- IMM: imm <= imem_data, pc <= pc+1.
- EXEC, ALU ops 1-7: alu_op per opcode, rf_write=1, rf_wr_sel=0, zflag <= alu_zero.
- EXEC, CMP: alu_op=SUB, rf_write=0, zflag <= alu_zero.
- EXEC, LDI: rf_write=1, rf_wr_sel=1; zflag unchanged.
- EXEC, JMP: pc <= imm.
- EXEC, JZ: pc <= imm if zflag=1, otherwise pc unchanged.
- EXEC, HALT: next state HALT; pc frozen.
- NOP and illegal opcodes: nothing happens.
- rf_sr1/rf_sr2/rf_dr are always driven from IR. rf_write is 1 only in EXEC of opcodes 1-8.
- alu_op is 0 outside EXEC and for non-ALU opcodes.
- PC arithmetic is mod 256: 0xFF+1 = 0x00, including mid-instruction (second byte at 0x00).

## Timing
- Reset values: state FETCH, pc/imem_addr 0x00, IR 0x00, imm 0x00, zflag 0, rf_write 0, rf_wr_sel 0, alu_op 0, halted 0.
- Reset dominates every state: no rf_write is asserted in a cycle where reset=1. An instruction in flight is discarded.
- One-byte instructions take 3 cycles; two-byte instructions take 5 cycles.
- Register write happens on the clock edge ending EXEC. The next FETCH sees updated registers and zflag.
- JZ tests zflag as registered before its EXEC, i.e. the result of the latest ALU op/CMP.
- HALT: halted=1 from the cycle after HALT's EXEC until reset. In HALT, imem_addr is held and rf_write=0.
- All outputs are registered or decoded from state/IR only. No combinational path from imem_data to outputs.

## Test plan
- Reset, then memory {0x81,0x05,0x8D,0x03,0x17} (LDI r0=5; LDI r3=3; ADD r1,r3 with r1 preloaded 0):
  - rf_write pulses at cycles 5, 10 and 13 after reset release.
  - rf_dr = 0, 3, 1 respectively; imm = 0x05 then 0x03.
  - alu_op = 0 on the third pulse.
- CMP with alu_zero=1 (byte 0xB1), then JZ 0x40 (bytes 0xA0,0x40): zflag=1 after CMP, next imem_addr after JZ = 0x40. With alu_zero=0, imem_addr continues at following byte.
- JMP at 0xFE with second byte at 0xFF = 0x10: PC fetches 0x10 next; a two-byte instruction at 0xFF reads its immediate from 0x00.
- HALT (0xF0): halted=1 and imem_addr frozen for 20 cycles; reset then restarts fetch at 0x00 with halted=0.
- Assert reset during EXEC of ADD: no rf_write that cycle, pc=0x00 and state FETCH next cycle.
- Opcode 0xC5: no rf_write, zflag unchanged, pc advances by 1 after 3 cycles.
